// File: rtl/rv32i_lsu_pkg.sv
// Shared types, byte-enable constants and decode helpers for the RV32I load/store unit.
package rv32i_lsu_pkg;

  // Decoded instruction mnemonics presented by the front end.
  typedef enum logic [5:0] {
    RV32I_ADD, RV32I_SUB, RV32I_AND, RV32I_OR, RV32I_XOR,
    RV32I_SLL, RV32I_SRL, RV32I_SRA, RV32I_SLT, RV32I_SLTU,
    RV32I_ADDI, RV32I_LUI, RV32I_AUIPC, RV32I_JAL, RV32I_JALR,
    RV32I_BEQ, RV32I_BNE,
    RV32I_LB, RV32I_LH, RV32I_LW, RV32I_LBU, RV32I_LHU,
    RV32I_SB, RV32I_SH, RV32I_SW
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_t;

  localparam logic [3:0] LSU_BE_BYTE = 4'b0001;
  localparam logic [3:0] LSU_BE_HALF = 4'b0011;
  localparam logic [3:0] LSU_BE_WORD = 4'b1111;

  function automatic logic is_mem_op(input RV32I_INSTRUCTION_MNEMONIC_t m);
    case (m)
      RV32I_LB, RV32I_LH, RV32I_LW, RV32I_LBU, RV32I_LHU,
      RV32I_SB, RV32I_SH, RV32I_SW: is_mem_op = 1'b1;
      default:                      is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input RV32I_INSTRUCTION_MNEMONIC_t m);
    is_store = (m == RV32I_SB) || (m == RV32I_SH) || (m == RV32I_SW);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                         input logic [1:0] ofs);
    case (m)
      RV32I_LH, RV32I_LHU, RV32I_SH: is_misaligned = ofs[0];
      RV32I_LW, RV32I_SW:            is_misaligned = (ofs != 2'b00);
      default:                       is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                        input logic [1:0] ofs);
    case (m)
      RV32I_LB, RV32I_LBU, RV32I_SB: lsu_be = LSU_BE_BYTE << ofs;
      RV32I_LH, RV32I_LHU, RV32I_SH: lsu_be = LSU_BE_HALF << {ofs[1], 1'b0};
      default:                       lsu_be = LSU_BE_WORD;
    endcase
  endfunction

  // Store data is replicated across all lanes so the byte enables alone pick the target.
  function automatic logic [31:0] lsu_wdata(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                            input logic [31:0] sd);
    case (m)
      RV32I_SB: lsu_wdata = {4{sd[7:0]}};
      RV32I_SH: lsu_wdata = {2{sd[15:0]}};
      default:  lsu_wdata = sd;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_lsu_extract.sv
// Combinational lane select and sign/zero extension of a read word.
module rv32i_lsu_extract
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0]                 rdata,
  input  logic [1:0]                  offset,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  output logic [31:0]                 data
);

  logic [31:0] shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign shifted   = rdata >> {offset, 3'b000};
  assign byte_lane = shifted[7:0];
  assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

  // Pick the addressed lane and extend it according to the load flavour.
  always_comb begin
    data = rdata;
    case (mnemonic)
      RV32I_LB:  data = {{24{byte_lane[7]}}, byte_lane};
      RV32I_LBU: data = {24'h000000, byte_lane};
      RV32I_LH:  data = {{16{half_lane[15]}}, half_lane};
      RV32I_LHU: data = {16'h0000, half_lane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: runs req/gnt/rvalid transactions, stalls the core,
// traps misaligned accesses and forces a bus error after a configurable timeout.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic [XLEN-1:0]             addr,
  input  logic [XLEN-1:0]             store_data,
  output logic                        stall,
  output logic                        done,
  output logic [XLEN-1:0]             load_data,
  output logic                        misaligned,
  output logic                        bus_error,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [XLEN-1:0]             mem_addr,
  output logic [3:0]                  mem_be,
  output logic [XLEN-1:0]             mem_wdata,
  input  logic                        mem_gnt,
  input  logic                        mem_rvalid,
  input  logic [XLEN-1:0]             mem_rdata
);

  localparam int             CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t                  state_reg, state_next;
  logic [XLEN-1:0]             addr_reg;
  RV32I_INSTRUCTION_MNEMONIC_t op_reg;
  logic [3:0]                  be_reg;
  logic [XLEN-1:0]             wdata_reg;
  logic                        we_reg;
  logic [CW-1:0]               count_reg;
  logic                        err_reg;
  logic                        misaligned_reg;
  logic [XLEN-1:0]             load_data_reg;

  logic                        accept;
  logic                        reject;
  logic                        capture;
  logic                        expire;
  logic                        limit_hit;
  logic [XLEN-1:0]             extracted;

  rv32i_lsu_extract u_extract (
    .rdata    (mem_rdata),
    .offset   (addr_reg[1:0]),
    .mnemonic (op_reg),
    .data     (extracted)
  );

  assign limit_hit = (TIMEOUT_CYCLES != 0) && (count_reg == LIMIT);
  assign reject    = (state_reg == LSU_IDLE) && start && is_mem_op(mnemonic)
                   && is_misaligned(mnemonic, addr[1:0]);

  // Next-state decode plus the state-derived handshake outputs.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    mem_req    = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state_reg)
      LSU_IDLE: begin
        if (start && is_mem_op(mnemonic) && !is_misaligned(mnemonic, addr[1:0])) begin
          stall      = 1'b1;
          accept     = 1'b1;
          state_next = LSU_REQ;
        end
      end
      LSU_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_next = we_reg ? LSU_DONE : LSU_WAIT;
        end else if (limit_hit) begin
          expire     = 1'b1;
          state_next = LSU_DONE;
        end
      end
      LSU_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          capture    = 1'b1;
          state_next = LSU_DONE;
        end else if (limit_hit) begin
          expire     = 1'b1;
          state_next = LSU_DONE;
        end
      end
      LSU_DONE: begin
        done       = 1'b1;
        state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  // Bus outputs are only driven during the request phase.
  assign mem_we     = mem_req & we_reg;
  assign mem_addr   = mem_req ? {addr_reg[XLEN-1:2], 2'b00} : '0;
  assign mem_be     = mem_req ? be_reg : 4'b0000;
  assign mem_wdata  = mem_req ? wdata_reg : '0;
  assign misaligned = misaligned_reg;
  assign bus_error  = done & err_reg;
  assign load_data  = load_data_reg;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LSU_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request latch, timeout counter, error flag and load result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg       <= '0;
      op_reg         <= RV32I_ADD;
      be_reg         <= 4'b0000;
      wdata_reg      <= '0;
      we_reg         <= 1'b0;
      count_reg      <= '0;
      err_reg        <= 1'b0;
      misaligned_reg <= 1'b0;
      load_data_reg  <= '0;
    end else begin
      misaligned_reg <= reject;
      if (accept) begin
        addr_reg  <= addr;
        op_reg    <= mnemonic;
        be_reg    <= lsu_be(mnemonic, addr[1:0]);
        wdata_reg <= lsu_wdata(mnemonic, store_data);
        we_reg    <= is_store(mnemonic);
        count_reg <= '0;
        err_reg   <= 1'b0;
      end else if ((state_reg == LSU_REQ) || (state_reg == LSU_WAIT)) begin
        count_reg <= count_reg + 1'b1;
      end
      if (expire) begin
        err_reg <= 1'b1;
      end
      if (capture) begin
        load_data_reg <= extracted;
      end else if (expire && !we_reg) begin
        load_data_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed testbench for rv32i_lsu: a default-timeout instance for normal traffic
// and a short-timeout instance for the bus error path.
module tb_rv32i_lsu;
  import rv32i_lsu_pkg::*;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic                        start_to;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  logic [31:0]                 addr;
  logic [31:0]                 store_data;
  logic                        mem_gnt, mem_rvalid;
  logic                        gnt_to, rvalid_to;
  logic [31:0]                 mem_rdata;

  logic        stall, done, misaligned, bus_error, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        stall_to, done_to, misaligned_to, bus_error_to, mem_req_to, mem_we_to;
  logic [31:0] load_data_to, mem_addr_to, mem_wdata_to;
  logic [3:0]  mem_be_to;

  int tests = 0;
  int fails = 0;

  rv32i_lsu #(.XLEN(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .start(start), .mnemonic(mnemonic), .addr(addr),
    .store_data(store_data), .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_error(bus_error), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  rv32i_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .start(start_to), .mnemonic(mnemonic), .addr(addr),
    .store_data(store_data), .stall(stall_to), .done(done_to), .load_data(load_data_to),
    .misaligned(misaligned_to), .bus_error(bus_error_to), .mem_req(mem_req_to),
    .mem_we(mem_we_to), .mem_addr(mem_addr_to), .mem_be(mem_be_to), .mem_wdata(mem_wdata_to),
    .mem_gnt(gnt_to), .mem_rvalid(rvalid_to), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load on the main instance: gnt at T+1, rvalid at T+2, done at T+3.
  task automatic run_load(input string tag, input RV32I_INSTRUCTION_MNEMONIC_t m,
                          input logic [31:0] a, input logic [31:0] rd,
                          input logic [3:0] be_exp, input logic [31:0] ld_exp);
    tick();
    start = 1'b1; mnemonic = m; addr = a;
    #1 check({tag, " stall_T"}, {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    #1;
    check({tag, " req"}, {31'd0, mem_req}, 32'd1);
    check({tag, " we"}, {31'd0, mem_we}, 32'd0);
    check({tag, " be"}, {28'd0, mem_be}, {28'd0, be_exp});
    check({tag, " maddr"}, mem_addr, {a[31:2], 2'b00});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    check({tag, " wait_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, " wait_stall"}, {31'd0, stall}, 32'd1);
    check({tag, " wait_done"}, {31'd0, done}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0;
    #1;
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " stall_done"}, {31'd0, stall}, 32'd0);
    check({tag, " data"}, load_data, ld_exp);
    $display("[TB] %s addr=0x%08h rdata=0x%08h load_data=0x%08h", tag, a, rd, load_data);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_to = 1'b0; mnemonic = RV32I_ADD;
    addr = '0; store_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    gnt_to = 1'b0; rvalid_to = 1'b0; mem_rdata = '0;
    #12;
    check("rst req", {31'd0, mem_req}, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst ld", load_data, 32'd0);
    check("rst mis", {31'd0, misaligned}, 32'd0);
    check("rst berr", {31'd0, bus_error}, 32'd0);
    tick();
    rst = 1'b0;
    $display("[TB] reset released");

    // SW, zero-wait: done at T+2.
    tick();
    start = 1'b1; mnemonic = RV32I_SW; addr = 32'h100; store_data = 32'hDEADBEEF;
    #1 check("sw stall_T", {31'd0, stall}, 32'd1);
    check("sw req_T", {31'd0, mem_req}, 32'd0);
    tick();
    start = 1'b0;
    #1;
    check("sw req", {31'd0, mem_req}, 32'd1);
    check("sw we", {31'd0, mem_we}, 32'd1);
    check("sw be", {28'd0, mem_be}, 32'hF);
    check("sw maddr", mem_addr, 32'h100);
    check("sw wdata", mem_wdata, 32'hDEADBEEF);
    check("sw stall_T1", {31'd0, stall}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    check("sw done", {31'd0, done}, 32'd1);
    check("sw stall_T2", {31'd0, stall}, 32'd0);
    check("sw req_T2", {31'd0, mem_req}, 32'd0);
    check("sw berr", {31'd0, bus_error}, 32'd0);
    tick();
    check("sw done_off", {31'd0, done}, 32'd0);
    $display("[TB] SW addr=0x00000100 wdata=0x%08h done", 32'hDEADBEEF);

    run_load("LB", RV32I_LB, 32'h203, 32'h80FF1234, 4'b1000, 32'hFFFFFF80);
    run_load("LBU", RV32I_LBU, 32'h203, 32'h80FF1234, 4'b1000, 32'h00000080);
    run_load("LH", RV32I_LH, 32'h202, 32'h80FF1234, 4'b1100, 32'hFFFF80FF);
    run_load("LHU", RV32I_LHU, 32'h200, 32'h80FF9234, 4'b0011, 32'h00009234);

    // Misaligned LH: pulse at T+1, no bus activity.
    tick();
    start = 1'b1; mnemonic = RV32I_LH; addr = 32'h101;
    #1 check("mis stall_T", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0;
    #1;
    check("mis pulse", {31'd0, misaligned}, 32'd1);
    check("mis req", {31'd0, mem_req}, 32'd0);
    check("mis done", {31'd0, done}, 32'd0);
    check("mis stall", {31'd0, stall}, 32'd0);
    tick();
    check("mis pulse_off", {31'd0, misaligned}, 32'd0);
    check("mis req2", {31'd0, mem_req}, 32'd0);
    $display("[TB] LH addr=0x00000101 misaligned");

    // Non-memory mnemonic is ignored.
    tick();
    start = 1'b1; mnemonic = RV32I_ADD; addr = 32'h100;
    #1 check("add stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0;
    #1 check("add req", {31'd0, mem_req}, 32'd0);
    check("add mis", {31'd0, misaligned}, 32'd0);
    $display("[TB] ADD ignored");

    // SH with gnt held off for 5 REQ cycles.
    tick();
    start = 1'b1; mnemonic = RV32I_SH; addr = 32'h402; store_data = 32'h0000ABCD;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("sh req_hold", {31'd0, mem_req}, 32'd1);
      check("sh be_hold", {28'd0, mem_be}, 32'hC);
      check("sh wdata_hold", mem_wdata, 32'hABCDABCD);
      check("sh maddr_hold", mem_addr, 32'h400);
      check("sh done_hold", {31'd0, done}, 32'd0);
      tick();
    end
    #1 check("sh req_gnt", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    check("sh done", {31'd0, done}, 32'd1);
    check("sh berr", {31'd0, bus_error}, 32'd0);
    check("sh ld_keep", load_data, 32'h00009234);
    $display("[TB] SH addr=0x00000402 wdata=0xabcdabcd done after delayed gnt");

    // Short-timeout instance: one good LW, then a LW with no gnt.
    tick();
    start_to = 1'b1; mnemonic = RV32I_LW; addr = 32'h300;
    tick();
    start_to = 1'b0; gnt_to = 1'b1;
    tick();
    gnt_to = 1'b0; rvalid_to = 1'b1; mem_rdata = 32'h12345678;
    tick();
    rvalid_to = 1'b0;
    #1 check("to prime_done", {31'd0, done_to}, 32'd1);
    check("to prime_data", load_data_to, 32'h12345678);
    tick();
    start_to = 1'b1; mnemonic = RV32I_LW; addr = 32'h304;
    tick();
    start_to = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("to req_wait", {31'd0, mem_req_to}, 32'd1);
      check("to done_early", {31'd0, done_to}, 32'd0);
      tick();
    end
    #1;
    check("to done", {31'd0, done_to}, 32'd1);
    check("to berr", {31'd0, bus_error_to}, 32'd1);
    check("to ld_zero", load_data_to, 32'd0);
    tick();
    check("to berr_off", {31'd0, bus_error_to}, 32'd0);
    $display("[TB] LW addr=0x00000304 timeout bus_error");

    // Reset during WAIT aborts immediately.
    tick();
    start = 1'b1; mnemonic = RV32I_LW; addr = 32'h500;
    tick();
    start = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1 check("rw stall_pre", {31'd0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rw req", {31'd0, mem_req}, 32'd0);
    check("rw stall", {31'd0, stall}, 32'd0);
    check("rw done", {31'd0, done}, 32'd0);
    check("rw ld", load_data, 32'd0);
    tick();
    rst = 1'b0;
    $display("[TB] reset during WAIT");

    // Reset during REQ drops mem_req immediately.
    tick();
    start = 1'b1; mnemonic = RV32I_SB; addr = 32'h601; store_data = 32'h5A;
    tick();
    start = 1'b0;
    #1 check("rq req_pre", {31'd0, mem_req}, 32'd1);
    check("rq be", {28'd0, mem_be}, 32'h2);
    check("rq wdata", mem_wdata, 32'h5A5A5A5A);
    #1 rst = 1'b1;
    #1 check("rq req", {31'd0, mem_req}, 32'd0);
    check("rq stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    $display("[TB] reset during REQ");

    run_load("LW post_rst", RV32I_LW, 32'h504, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
